// File: rtl/l1_threshold_servo.sv
// Wishbone initiator that servos each beam's L1 threshold one step per counting period toward a target trigger count.
// One transaction in flight; each holds until ack/err/rty (or aborts on timeout) and is followed by one idle bus cycle.
module l1_threshold_servo #(
  parameter int unsigned NBEAMS        = 2,
  parameter logic [17:0] THRESH_INIT   = 18'h0_4000,
  parameter int unsigned POLL_INTERVAL = 1024,
  parameter int unsigned ACK_TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        enable_i,
  input  logic [31:0] target_count_i,
  input  logic [31:0] tolerance_i,
  input  logic [17:0] step_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [21:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  input  logic [31:0] wb_dat_i,
  output logic        busy_o,
  output logic        cycle_done_o,
  output logic        error_o,
  input  logic [7:0]  thresh_rd_beam_i,
  output logic [17:0] thresh_rd_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_WAIT, S_POLL, S_READ_CNT, S_CALC, S_WR_THR, S_STAGE, S_UPDATE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  b_q, b_d;
  logic [31:0] cnt_q, cnt_d;
  logic        term_q, term_d;
  logic [31:0] rd_q, rd_d;
  logic        error_q, error_d;
  logic        en_q;
  logic [17:0] thr_q [NBEAMS];
  logic [17:0] thr_d [NBEAMS];

  logic        txn_state, active, bus_ok, bus_err;
  logic [17:0] cur_thr, new_thr;
  logic [32:0] hi_bound, lo_bound;
  logic [18:0] thr_sum;

  always_comb begin
    cur_thr     = '0;
    thresh_rd_o = '0;
    for (int i = 0; i < NBEAMS; i++) begin
      if (b_q == 8'(i)) cur_thr = thr_q[i];
      if (thresh_rd_beam_i == 8'(i)) thresh_rd_o = thr_q[i];
    end
  end

  // 33-bit bounds so target+tolerance cannot wrap; lower bound clamps at zero.
  always_comb begin
    hi_bound = {1'b0, target_count_i} + {1'b0, tolerance_i};
    lo_bound = (tolerance_i > target_count_i) ? 33'd0 : {1'b0, target_count_i - tolerance_i};
    thr_sum  = {1'b0, cur_thr} + {1'b0, step_i};
    new_thr  = cur_thr;
    if ({1'b0, rd_q} > hi_bound)
      new_thr = thr_sum[18] ? 18'h3FFFF : thr_sum[17:0];
    else if ({1'b0, rd_q} < lo_bound)
      new_thr = (cur_thr > step_i) ? cur_thr - step_i : 18'd0;
  end

  assign txn_state = state_q inside {S_START, S_POLL, S_READ_CNT, S_WR_THR, S_STAGE, S_UPDATE};
  // term_q marks the mandatory idle cycle after an acked transaction.
  assign active    = txn_state && !term_q;
  assign bus_ok    = active && wb_ack_i && !wb_err_i && !wb_rty_i;
  assign bus_err   = active && (wb_err_i || wb_rty_i || (!wb_ack_i && cnt_q == ACK_TIMEOUT));

  always_comb begin
    wb_cyc_o = active;
    wb_stb_o = active;
    wb_we_o  = 1'b0;
    wb_adr_o = '0;
    wb_dat_o = '0;
    wb_sel_o = '0;
    if (active) begin
      case (state_q)
        S_START: begin
          wb_we_o  = 1'b1;
          wb_dat_o = 32'd1;
          wb_sel_o = 4'b0001;
        end
        S_POLL: wb_sel_o = 4'b1111;
        S_READ_CNT: begin
          wb_adr_o = 22'h400 | {12'd0, b_q, 2'b00};
          wb_sel_o = 4'b1111;
        end
        S_WR_THR: begin
          wb_we_o  = 1'b1;
          wb_adr_o = 22'h400 | {12'd0, b_q, 2'b00};
          wb_dat_o = {14'd0, cur_thr};
          wb_sel_o = 4'b0111;
        end
        S_STAGE: begin
          wb_we_o  = 1'b1;
          wb_adr_o = 22'h800 | {12'd0, b_q, 2'b00};
          wb_dat_o = 32'd1;
          wb_sel_o = 4'b0010;
        end
        S_UPDATE: begin
          wb_we_o  = 1'b1;
          wb_dat_o = 32'd2;
          wb_sel_o = 4'b0010;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    rd_d    = rd_q;
    thr_d   = thr_q;
    error_d = error_q;
    term_d  = term_q;
    if (enable_i && !en_q) error_d = 1'b0;
    if (bus_ok && !wb_we_o) rd_d = wb_dat_i;
    if (bus_ok) term_d = 1'b1;

    case (state_q)
      S_IDLE:  if (enable_i && !error_q) state_d = S_START;
      S_WAIT:  if (cnt_q == POLL_INTERVAL - 1) state_d = S_POLL;
      S_CALC: begin
        for (int i = 0; i < NBEAMS; i++)
          if (b_q == 8'(i)) thr_d[i] = new_thr;
        state_d = S_WR_THR;
      end
      default: begin
        if (bus_err) begin
          state_d = S_IDLE;
          error_d = 1'b1;
        end else if (term_q) begin
          case (state_q)
            S_START:    state_d = S_WAIT;
            S_POLL: begin
              if (rd_q[0]) begin
                b_d     = '0;
                state_d = S_READ_CNT;
              end else begin
                state_d = S_WAIT;
              end
            end
            S_READ_CNT: state_d = S_CALC;
            S_WR_THR:   state_d = S_STAGE;
            S_STAGE: begin
              if (32'(b_q) < NBEAMS - 1) begin
                b_d     = b_q + 8'd1;
                state_d = S_READ_CNT;
              end else begin
                state_d = S_UPDATE;
              end
            end
            S_UPDATE:   state_d = enable_i ? S_START : S_IDLE;
            default:    state_d = S_IDLE;
          endcase
        end
      end
    endcase

    if (state_d != state_q) term_d = 1'b0;
    cnt_d = (state_d != state_q || state_q == S_IDLE) ? 32'd0 : cnt_q + 32'd1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q <= S_IDLE;
      b_q     <= '0;
      cnt_q   <= '0;
      term_q  <= 1'b0;
      rd_q    <= '0;
      error_q <= 1'b0;
      en_q    <= 1'b0;
      for (int i = 0; i < NBEAMS; i++) thr_q[i] <= THRESH_INIT;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      term_q  <= term_d;
      rd_q    <= rd_d;
      error_q <= error_d;
      en_q    <= enable_i;
      thr_q   <= thr_d;
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign cycle_done_o = (state_q == S_UPDATE) && term_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_l1_threshold_servo.sv
// Directed bench for l1_threshold_servo: wishbone target model with a transaction scoreboard.
module tb_l1_threshold_servo;
  localparam int NB = 2;
  localparam int PI = 8;
  localparam int AT = 20;
  localparam logic [17:0] TINIT = 18'h0_4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, enable;
  logic [31:0] target, tol;
  logic [17:0] step;
  logic        cyc, stb, we;
  logic [21:0] adr;
  logic [31:0] dato;
  logic [3:0]  sel;
  logic        ack, err, rty;
  logic [31:0] dati;
  logic        busy, cdone, error;
  logic [7:0]  rd_beam;
  logic [17:0] rd_thr;

  l1_threshold_servo #(.NBEAMS(NB), .THRESH_INIT(TINIT), .POLL_INTERVAL(PI), .ACK_TIMEOUT(AT)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .enable_i(enable),
    .target_count_i(target), .tolerance_i(tol), .step_i(step),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr), .wb_dat_o(dato), .wb_sel_o(sel),
    .wb_ack_i(ack), .wb_err_i(err), .wb_rty_i(rty), .wb_dat_i(dati),
    .busy_o(busy), .cycle_done_o(cdone), .error_o(error),
    .thresh_rd_beam_i(rd_beam), .thresh_rd_o(rd_thr)
  );

  typedef struct {
    logic        we;
    logic [21:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } txn_t;

  int total = 0;
  int bad = 0;
  txn_t        sbq[$];
  logic [31:0] counts[NB];
  logic [17:0] model_thr[NB];
  int          polls_total = 0;
  int          poll_goal = 0;
  bit          withhold = 1'b0;
  int          txn_n = 0;
  int          last_len = 0;
  int          done_pulses = 0;
  longint      cyc_no = 0;
  longint      poll_t[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] model_calc(input logic [17:0] thr, input longint cnt,
                                             input longint tgt, input longint tl, input longint stp);
    longint r;
    r = longint'(thr);
    if (cnt > tgt + tl) begin
      r = r + stp;
      if (r > 262143) r = 262143;
    end else if (cnt < tgt - tl) begin
      r = r - stp;
      if (r < 0) r = 0;
    end
    return 18'(r);
  endfunction

  // Target model: acks on the second cycle of every transaction and scoreboards its first cycle.
  always @(negedge clk) begin : target_model
    txn_t e;
    int   idx;
    cyc_no++;
    if (cdone) done_pulses++;
    if (cyc && stb) txn_n++; else txn_n = 0;
    if (txn_n > 0) last_len = txn_n;
    if (txn_n == 1) begin
      if (!we && adr == 22'h0) poll_t.push_back(cyc_no);
      if (sbq.size() == 0) begin
        check("sb_unexpected_txn_adr", 64'(adr), 64'hDEAD_0000_0000);
      end else begin
        e = sbq.pop_front();
        check("txn_we", 64'(we), 64'(e.we));
        check("txn_adr", 64'(adr), 64'(e.adr));
        if (e.we) begin
          check("txn_dat", 64'(dato), 64'(e.dat));
          check("txn_sel", 64'(sel), 64'(e.sel));
        end
      end
    end
    ack  = 1'b0;
    dati = 32'h0;
    if (txn_n == 2 && !(withhold && we && adr == 22'h400)) begin
      ack = 1'b1;
      if (!we && adr == 22'h0) begin
        dati = (polls_total >= poll_goal) ? 32'd1 : 32'd0;
        polls_total++;
      end else if (!we) begin
        idx = int'(adr - 22'h400) >> 2;
        if (idx < NB) dati = counts[idx];
      end
    end
  end

  task automatic push_w(input logic [21:0] a, input logic [31:0] d, input logic [3:0] s);
    txn_t t;
    t.we = 1'b1; t.adr = a; t.dat = d; t.sel = s;
    sbq.push_back(t);
  endtask

  task automatic push_r(input logic [21:0] a);
    txn_t t;
    t.we = 1'b0; t.adr = a; t.dat = '0; t.sel = '0;
    sbq.push_back(t);
  endtask

  task automatic push_cycle(input int npz);
    logic [21:0] a;
    push_w(22'h0, 32'd1, 4'b0001);
    for (int p = 0; p <= npz; p++) push_r(22'h0);
    for (int b = 0; b < NB; b++) begin
      a = 22'h400 + 22'(4 * b);
      push_r(a);
      model_thr[b] = model_calc(model_thr[b], longint'(counts[b]), longint'(target),
                                longint'(tol), longint'(step));
      push_w(a, {14'd0, model_thr[b]}, 4'b0111);
      push_w(22'h800 + 22'(4 * b), 32'd1, 4'b0010);
    end
    push_w(22'h0, 32'd2, 4'b0010);
  endtask

  task automatic check_thr(input string tag);
    for (int b = 0; b < NB; b++) begin
      rd_beam = 8'(b);
      #1;
      check($sformatf("%s_thr%0d", tag, b), 64'(rd_thr), 64'(model_thr[b]));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cyc"}, 64'(cyc), 64'd0);
    check({tag, "_stb"}, 64'(stb), 64'd0);
    check({tag, "_we"}, 64'(we), 64'd0);
    check({tag, "_adr"}, 64'(adr), 64'd0);
    check({tag, "_dat"}, 64'(dato), 64'd0);
    check({tag, "_sel"}, 64'(sel), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_cdone"}, 64'(cdone), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sbq.delete();
    for (int b = 0; b < NB; b++) model_thr[b] = TINIT;
  endtask

  task automatic run_cycle(input logic [31:0] c0, input logic [31:0] c1, input int npz, input string tag);
    int dp0;
    int n;
    counts[0] = c0;
    counts[1] = c1;
    poll_goal = polls_total + npz;
    push_cycle(npz);
    dp0 = done_pulses;
    enable = 1'b1;
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    check({tag, "_started"}, 64'(busy), 64'd1);
    enable = 1'b0;
    n = 0;
    while (!cdone && n < 3000) begin @(negedge clk); n++; end
    check({tag, "_cycle_done"}, 64'(cdone), 64'd1);
    repeat (3) @(negedge clk);
    check({tag, "_idle_after"}, 64'(busy), 64'd0);
    check({tag, "_done_pulses"}, 64'(done_pulses - dp0), 64'd1);
    check({tag, "_sb_empty"}, 64'(sbq.size()), 64'd0);
    check_thr(tag);
  endtask

  initial begin
    int n;
    int p0;
    err = 1'b0; rty = 1'b0; ack = 1'b0; dati = '0;
    rd_beam = '0;
    target = 32'd1000; tol = 32'd10; step = 18'd16;
    counts[0] = '0; counts[1] = '0;

    // Reset state
    do_reset();
    @(negedge clk);
    check_reset_vals("reset");
    check_thr("reset");

    // Main servo cycle: one beam above band, one below
    run_cycle(32'd2000, 32'd500, 0, "main");
    check("main_thr0_value", 64'(model_thr[0]), 64'h4010);
    check("main_thr1_value", 64'(model_thr[1]), 64'h3FF0);

    // Counts exactly on the band edges leave thresholds alone
    do_reset();
    @(negedge clk);
    run_cycle(32'd1010, 32'd990, 0, "edge");

    // Done bit low for three polls
    p0 = poll_t.size();
    run_cycle(32'd1000, 32'd1000, 3, "poll");
    check("poll_count", 64'(poll_t.size() - p0), 64'd4);
    for (int k = 1; k < 4; k++)
      if (p0 + k < poll_t.size())
        check($sformatf("poll_gap%0d", k), 64'(poll_t[p0 + k] - poll_t[p0 + k - 1]), 64'(PI + 3));

    // Saturation at the top and clamp at zero
    step = 18'h3BFF8;
    run_cycle(32'd2000, 32'd1000, 0, "sat_a");
    step = 18'h03FF8;
    run_cycle(32'd1000, 32'd500, 0, "sat_b");
    step = 18'd16;
    run_cycle(32'd2000, 32'd500, 0, "sat_c");
    check("sat_top", 64'(model_thr[0]), 64'h3FFFF);
    check("sat_zero", 64'(model_thr[1]), 64'h0);

    // Tolerance larger than target, and a target near the 32-bit limit
    target = 32'd5; tol = 32'd10;
    run_cycle(32'd0, 32'd16, 0, "wide_tol");
    target = 32'hFFFF_FFFF; tol = 32'd1;
    run_cycle(32'hFFFF_FFFF, 32'd0, 0, "big_tgt");

    // Ack withheld on WR_THR: timeout aborts, error is sticky until enable toggles
    target = 32'd1000; tol = 32'd10; step = 18'd16;
    counts[0] = 32'd500; counts[1] = 32'd500;
    poll_goal = polls_total;
    push_w(22'h0, 32'd1, 4'b0001);
    push_r(22'h0);
    push_r(22'h400);
    model_thr[0] = model_calc(model_thr[0], 500, 1000, 10, 16);
    push_w(22'h400, {14'd0, model_thr[0]}, 4'b0111);
    withhold = 1'b1;
    enable = 1'b1;
    n = 0;
    while (!error && n < PI + 200) begin @(negedge clk); n++; end
    check("to_error", 64'(error), 64'd1);
    check("to_cyc_len", 64'(last_len), 64'(AT + 1));
    check("to_busy", 64'(busy), 64'd0);
    check("to_cyc", 64'(cyc), 64'd0);
    repeat (10) @(negedge clk);
    check("to_no_restart", 64'(busy), 64'd0);
    check("to_sb_empty", 64'(sbq.size()), 64'd0);
    check_thr("to_kept");
    withhold = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    run_cycle(32'd1000, 32'd1000, 0, "recover");
    check("recover_error_clear", 64'(error), 64'd0);

    // Reset pulsed during READ_CNT
    counts[0] = 32'd2000; counts[1] = 32'd500;
    poll_goal = polls_total;
    push_cycle(0);
    enable = 1'b1;
    n = 0;
    while (!(cyc && !we && adr == 22'h400) && n < 200) begin @(negedge clk); n++; end
    check("rst_reached_read", 64'(cyc && !we && adr == 22'h400), 64'd1);
    rst_n  = 1'b0;
    enable = 1'b0;
    @(posedge clk);
    #1;
    check_reset_vals("midrst");
    sbq.delete();
    for (int b = 0; b < NB; b++) model_thr[b] = TINIT;
    check_thr("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_stays_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l1_threshold_servo.md
# l1_threshold_servo

Wishbone initiator that drives the L1 threshold/scaler target interface from the other end. It repeatedly starts a trigger-rate counting period, polls for completion, reads each beam's trigger count, and moves each beam's 18-bit threshold one step toward a target count. It then writes, stages and globally updates the new thresholds. It sits in the wishbone clock domain between the housekeeping crossbar and the L1 trigger's threshold port, so it replaces manual threshold tuning by software.

## Interface
- NBEAMS, 2: number of beams serviced, 1..256
- THRESH_INIT, 18'h0_4000: threshold loaded into every beam's shadow register at reset
- POLL_INTERVAL, 1024: wb_clk_i cycles between done-bit polls, ≥1
- ACK_TIMEOUT, 255: cycles without ack/err/rty before a transaction aborts
- wb_clk_i  in  1  wishbone clock, the only clock
- wb_rst_n_i  in  1  synchronous, active-low reset
- enable_i  in  1  level; servo cycles run while high
- target_count_i  in  32  desired triggers per counting period
- tolerance_i  in  32  dead band around the target
- step_i  in  18  threshold increment/decrement per cycle
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  wishbone host strobes
- wb_adr_o  out  22  byte address
- wb_dat_o  out  32  write data
- wb_sel_o  out  4  byte selects
- wb_ack_i, wb_err_i, wb_rty_i  in  1  cycle terminations
- wb_dat_i  in  32  read data
- busy_o  out  1  high whenever the FSM is not in IDLE
- cycle_done_o  out  1  one-cycle pulse when UPDATE is acknowledged
- error_o  out  1  sticky; set on err, rty or timeout; cleared by reset or by a rising edge of enable_i
- thresh_rd_beam_i  in  8  beam index for status readback
- thresh_rd_o  out  18  shadow threshold of the selected beam, combinational mux

## Operation
- Target address map:
  - 0x000: write sel=0001 dat bit0=1 starts a count; write sel=0010 dat bit1=1 applies staged thresholds; read bit0 = count done.
  - 0x400+4b: read returns beam b's count; write sel=0111 loads beam b's threshold.
  - 0x800+4b: write sel=0010 dat=1 stages beam b.
- FSM states and transitions:
  - IDLE: stays until enable_i=1, then goes to START.
  - START: write 0x000, dat 1, sel 0001.
  - WAIT: count POLL_INTERVAL cycles, then go to POLL.
  - POLL: read 0x000. bit0=0 returns to WAIT; bit0=1 sets b=0 and goes to READ_CNT.
  - READ_CNT: read 0x400+4b and latch the count.
  - CALC: one cycle.
  - WR_THR: write 0x400+4b, dat {14'b0,thr[b]}, sel 0111.
  - STAGE: write 0x800+4b, dat 1, sel 0010. If b<NBEAMS-1, increment b and go to READ_CNT; otherwise go to UPDATE.
  - UPDATE: write 0x000, dat 2, sel 0010. Pulse cycle_done_o, then go to START if enable_i=1, else IDLE.
- CALC arithmetic uses 33-bit unsigned math; no overflow of target±tolerance.
  - If count > target+tol: thr = min(thr+step, 2^18-1).
  - If count < target-tol: thr = max(thr-step, 0). When tol > target, the lower bound is 0.
  - Otherwise thr is unchanged.
  - Equality at either bound means no change.
- enable_i falling mid-cycle does not abort. The current servo cycle completes through UPDATE, so targets never hold half-written thresholds.
- err, rty or timeout on any transaction:
  - drop cyc/stb the next cycle, set error_o and return to IDLE;
  - shadow thresholds keep their values, including any already-computed beam;
  - the next START is not issued until enable_i goes low, then high again.

## Timing
- Reset values: cyc/stb/we=0, adr=0, dat=0, sel=0, busy_o=0, cycle_done_o=0, error_o=0, FSM=IDLE, every thr=THRESH_INIT.
- Each transaction:
  - cyc, stb, we, adr, dat and sel assert together on the first cycle of the transaction state;
  - they stay stable until the cycle ack/err/rty is sampled high, inclusive;
  - cyc and stb are low the following cycle, with at least one idle cycle between transactions.
- Read data is captured on the ack cycle.
- Timeout fires when the wait counter equals ACK_TIMEOUT with no termination. An ack arriving in that same cycle wins.
- CALC is exactly one cycle after the READ_CNT ack; its result is visible on thresh_rd_o the next cycle.
- cycle_done_o is high for the cycle after the UPDATE ack.
- Reset asserted mid-transaction drops cyc/stb in the cycle after wb_rst_n_i is sampled low.

## Test plan
- Target model acks in 2 cycles; done=1 on first poll; NBEAMS=2; target=1000, tol=10, step=16; counts 2000 and 500; thr 0x4000 -> bus writes 0x4010 to 0x400 and 0x3FF0 to 0x404, stages 0x800/0x804 with sel 0010, then writes 0x000 dat 2; one cycle_done_o pulse.
- Count exactly 1010 and exactly 990 -> no change to thr; WR_THR still rewrites 0x4000.
- thr=0x3FFF8, step=16, count high -> 0x3FFFF. thr=8, count low -> 0.
- done=0 for 3 polls -> 4 reads of 0x000 spaced POLL_INTERVAL+transaction cycles apart, then count reads.
- Model withholds ack on WR_THR -> cyc drops after ACK_TIMEOUT; error_o=1; busy_o=0. Toggling enable_i clears error_o and restarts at START.
- Reset pulsed mid-READ_CNT -> all outputs at reset values next cycle; thresh_rd_o reads THRESH_INIT for every beam.
